// File: rtl/tpu_host_driver_pkg.sv
// Shared types and TPU address map for the TPU host driver.
package tpu_drv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    CLR_C,
    START,
    WAIT,
    READ
  } state_e;

  localparam int unsigned A_BASE       = 32'h100;
  localparam int unsigned A_ROW_STRIDE = 8;
  localparam int unsigned B_BASE       = 32'h200;
  localparam int unsigned C_BASE       = 32'h300;
  localparam int unsigned START_ADDR   = 32'h400;
  localparam int unsigned C_ROW_STRIDE = 16;
  localparam int unsigned C_HI_OFS     = 8;

  // C word k is row k/2, low half for even k and high half for odd k.
  function automatic int unsigned c_word_addr(input int unsigned k);
    return C_BASE + C_ROW_STRIDE * (k >> 1) + C_HI_OFS * (k & 32'd1);
  endfunction

endpackage

// File: rtl/tpu_host_driver_if.sv
// Host-stream and TPU memory-port signals of the driver, with driver/peer views.
interface tpu_host_driver_if #(
  parameter int ADDRW = 16,
  parameter int DATAW = 64
);
  logic             job_valid;
  logic             job_ready;
  logic             in_valid;
  logic             in_ready;
  logic [DATAW-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [DATAW-1:0] out_data;
  logic             done;
  logic             tpu_r_w;
  logic [ADDRW-1:0] tpu_addr;
  logic [DATAW-1:0] tpu_wdata;
  logic [DATAW-1:0] tpu_rdata;

  modport master (
    input  job_valid, in_valid, in_data, out_ready, tpu_rdata,
    output job_ready, in_ready, out_valid, out_data, done,
           tpu_r_w, tpu_addr, tpu_wdata
  );

  modport slave (
    output job_valid, in_valid, in_data, out_ready, tpu_rdata,
    input  job_ready, in_ready, out_valid, out_data, done,
           tpu_r_w, tpu_addr, tpu_wdata
  );
endinterface

// File: rtl/tpu_host_driver_wait_timer.sv
// Loadable down-counter; expired_o is high while the count sits at zero.
module tpu_drv_wait_timer #(
  parameter int MAXV = 32,
  parameter int W    = $clog2(MAXV + 1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         expired_o
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/tpu_host_driver.sv
// Sequences one TPU matmul job: load A/B, start, wait, stream C back.
// Define TPU_DRV_CLEAR_C_EN to zero C before each start (otherwise C accumulates).
module tpu_host_driver
  import tpu_drv_pkg::*;
#(
  parameter int BITS_AB     = 8,
  parameter int BITS_C      = 16,
  parameter int DIM         = 8,
  parameter int ADDRW       = 16,
  parameter int DATAW       = 64,
  parameter int COMPUTE_CYC = 4 * DIM
) (
  input  logic               clk,
  input  logic               rst_n,
  tpu_host_driver_if.master  bus
);
  localparam int CW = $clog2(2 * DIM);
  localparam int TW = $clog2(COMPUTE_CYC + 1);
  localparam logic [CW-1:0] ROW_LAST  = CW'(DIM - 1);
  localparam logic [CW-1:0] WORD_LAST = CW'(2 * DIM - 1);
  // Only the bits that carry matrix elements are forwarded.
  localparam logic [DATAW-1:0] AB_MASK = {DATAW{1'b1}} >> (DATAW - DIM * BITS_AB);
  localparam logic [DATAW-1:0] C_MASK  = {DATAW{1'b1}} >> (DATAW - (DIM / 2) * BITS_C);

`ifdef TPU_DRV_CLEAR_C_EN
  localparam state_e AFTER_B = CLR_C;
`else
  localparam state_e AFTER_B = START;
`endif

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              rw_q, rw_d;
  logic [ADDRW-1:0]  addr_q, addr_d;
  logic [DATAW-1:0]  wdata_q, wdata_d;
  logic              out_valid_q, out_valid_d;
  logic [DATAW-1:0]  out_data_q, out_data_d;
  logic              rd_pend_q, rd_pend_d;
  logic              done_q, done_d;
  logic              tmr_load, tmr_expired;

  logic job_hs, in_hs, out_hs, row_last, word_last, in_ready;

  assign in_ready  = (state_q == LOAD_A) || (state_q == LOAD_B);
  assign job_hs    = bus.job_valid && (state_q == IDLE);
  assign in_hs     = bus.in_valid && in_ready;
  assign out_hs    = out_valid_q && bus.out_ready;
  assign row_last  = (cnt_q == ROW_LAST);
  assign word_last = (cnt_q == WORD_LAST);

  tpu_drv_wait_timer #(
    .MAXV (COMPUTE_CYC),
    .W    (TW)
  ) u_wait_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_load),
    .load_val_i (TW'(COMPUTE_CYC)),
    .en_i       (state_q == WAIT),
    .expired_o  (tmr_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (job_hs) state_d = LOAD_A;
      LOAD_A: if (in_hs && row_last) state_d = LOAD_B;
      LOAD_B: if (in_hs && row_last) state_d = AFTER_B;
`ifdef TPU_DRV_CLEAR_C_EN
      CLR_C:  if (word_last) state_d = START;
`endif
      START:  state_d = WAIT;
      WAIT:   if (tmr_expired) state_d = READ;
      READ:   if (out_hs && word_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus and stream outputs are computed here and registered below, so the
  // bus shows each access the cycle after the decision to make it.
  always_comb begin
    cnt_d       = cnt_q;
    rw_d        = 1'b0;
    addr_d      = '0;
    wdata_d     = '0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    rd_pend_d   = rd_pend_q;
    done_d      = 1'b0;
    tmr_load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (job_hs) cnt_d = '0;
      end
      LOAD_A: begin
        if (in_hs) begin
          rw_d    = 1'b1;
          addr_d  = ADDRW'(A_BASE + A_ROW_STRIDE * 32'(cnt_q));
          wdata_d = bus.in_data & AB_MASK;
          cnt_d   = row_last ? '0 : cnt_q + CW'(1);
        end
      end
      LOAD_B: begin
        if (in_hs) begin
          rw_d    = 1'b1;
          addr_d  = ADDRW'(B_BASE);
          wdata_d = bus.in_data & AB_MASK;
          cnt_d   = row_last ? '0 : cnt_q + CW'(1);
        end
      end
`ifdef TPU_DRV_CLEAR_C_EN
      CLR_C: begin
        rw_d   = 1'b1;
        addr_d = ADDRW'(c_word_addr(32'(cnt_q)));
        cnt_d  = word_last ? '0 : cnt_q + CW'(1);
      end
`endif
      START: begin
        rw_d     = 1'b1;
        addr_d   = ADDRW'(START_ADDR);
        tmr_load = 1'b1;
      end
      WAIT: begin
        if (tmr_expired) begin
          addr_d    = ADDRW'(c_word_addr(32'd0));
          rd_pend_d = 1'b1;
          cnt_d     = '0;
        end
      end
      READ: begin
        if (rd_pend_q) begin
          out_data_d  = bus.tpu_rdata & C_MASK;
          out_valid_d = 1'b1;
          rd_pend_d   = 1'b0;
        end else if (out_hs) begin
          out_valid_d = 1'b0;
          if (word_last) begin
            done_d = 1'b1;
            cnt_d  = '0;
          end else begin
            // Next read goes out on the handshake edge: one word per 2 cycles.
            cnt_d     = cnt_q + CW'(1);
            addr_d    = ADDRW'(c_word_addr(32'(cnt_q) + 32'd1));
            rd_pend_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      rw_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      rd_pend_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      rw_q        <= rw_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      rd_pend_q   <= rd_pend_d;
      done_q      <= done_d;
    end
  end

  assign bus.job_ready = (state_q == IDLE);
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.done      = done_q;
  assign bus.tpu_r_w   = rw_q;
  assign bus.tpu_addr  = addr_q;
  assign bus.tpu_wdata = wdata_q;

endmodule

// File: tb/tb_tpu_host_driver.sv
// Directed bench for tpu_host_driver with a small behavioural TPU attached.
module tb_tpu_host_driver;
  localparam int DIM   = 8;
  localparam int ADDRW = 16;
  localparam int DATAW = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  tpu_host_driver_if #(.ADDRW(ADDRW), .DATAW(DATAW)) bus ();

  tpu_host_driver #(
    .BITS_AB(8), .BITS_C(16), .DIM(DIM), .ADDRW(ADDRW), .DATAW(DATAW),
    .COMPUTE_CYC(4 * DIM)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Behavioural TPU: A rows, B push FIFO, C accumulate on start.
  logic [DATAW-1:0] a_mem [DIM];
  logic [DATAW-1:0] b_mem [DIM];
  logic [DATAW-1:0] c_mem [2*DIM];
  int b_idx = 0;

  initial begin
    for (int i = 0; i < DIM; i++) begin a_mem[i] = '0; b_mem[i] = '0; end
    for (int i = 0; i < 2*DIM; i++) c_mem[i] = '0;
  end

  function automatic logic [63:0] c_calc(input int w);
    logic [63:0] r;
    int j, s, row;
    r = c_mem[w];
    row = w / 2;
    for (int jj = 0; jj < 4; jj++) begin
      j = (w % 2) * 4 + jj;
      s = 0;
      for (int k = 0; k < DIM; k++)
        s += int'(a_mem[row][k*8 +: 8]) * int'(b_mem[k][j*8 +: 8]);
      r[jj*16 +: 16] = r[jj*16 +: 16] + 16'(s);
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (bus.tpu_r_w) begin
      if (bus.tpu_addr >= 16'h100 && bus.tpu_addr < 16'h140)
        a_mem[int'(bus.tpu_addr - 16'h100) / 8] <= bus.tpu_wdata;
      else if (bus.tpu_addr == 16'h200) begin
        b_mem[b_idx] <= bus.tpu_wdata;
        b_idx <= (b_idx + 1) % DIM;
      end else if (bus.tpu_addr >= 16'h300 && bus.tpu_addr < 16'h380)
        c_mem[int'(bus.tpu_addr - 16'h300) / 8] <= bus.tpu_wdata;
      else if (bus.tpu_addr == 16'h400)
        for (int w = 0; w < 2*DIM; w++) c_mem[w] <= c_calc(w);
    end
  end

  always_comb begin
    bus.tpu_rdata = '0;
    if (!bus.tpu_r_w && bus.tpu_addr >= 16'h300 && bus.tpu_addr < 16'h380)
      bus.tpu_rdata = c_mem[int'(bus.tpu_addr - 16'h300) / 8];
  end

  // Bus monitor, sampled on the falling edge.
  int cyc = 0, start_cyc = 0, first_rd_cyc = 0, n_start = 0;
  logic [15:0] wr_addr_q [$];
  logic [63:0] wr_data_q [$];
  logic [15:0] rd_addr_q [$];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (bus.tpu_r_w) begin
      wr_addr_q.push_back(bus.tpu_addr);
      wr_data_q.push_back(bus.tpu_wdata);
      if (bus.tpu_addr == 16'h400) begin
        start_cyc <= cyc;
        n_start <= n_start + 1;
      end
    end else if (bus.tpu_addr != '0) begin
      rd_addr_q.push_back(bus.tpu_addr);
      if (bus.tpu_addr == 16'h300) first_rd_cyc <= cyc;
    end
  end

  function automatic logic [63:0] a_row(input int r);
    logic [63:0] v;
    v = 64'd1;
    return v << (r * 8);
  endfunction

  function automatic logic [63:0] b_row(input int i);
    logic [63:0] v;
    v = '0;
    for (int j = 0; j < DIM; j++) v[j*8 +: 8] = 8'(i + j);
    return v;
  endfunction

  // Identity A with B[i][j]=i+j: C word k holds f*(row + half*4 + jj).
  function automatic logic [63:0] exp_c(input int k, input int f);
    logic [63:0] v;
    v = '0;
    for (int jj = 0; jj < 4; jj++) v[jj*16 +: 16] = 16'(f * ((k / 2) + (k % 2) * 4 + jj));
    return v;
  endfunction

  task automatic request_job();
    int t;
    bus.job_valid = 1'b1;
    t = 0;
    while (!bus.job_ready && t < 50) begin @(negedge clk); t++; end
    check_val("job_ready", 64'(bus.job_ready), 64'd1);
    @(negedge clk);
    bus.job_valid = 1'b0;
  endtask

  task automatic send_word(input logic [63:0] d);
    int t;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    t = 0;
    while (!bus.in_ready && t < 20) begin @(negedge clk); t++; end
    check_val("in_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
  endtask

  task automatic run_inputs(input bit bubble);
    wr_addr_q.delete();
    wr_data_q.delete();
    rd_addr_q.delete();
    request_job();
    for (int w = 0; w < 2*DIM; w++) begin
      send_word(w < DIM ? a_row(w) : b_row(w - DIM));
      if (bubble && (w % 2 == 0)) begin
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic collect(input int stall_k, input int f);
    int t;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 2*DIM; k++) begin
      t = 0;
      while (!bus.out_valid && t < 100) begin @(negedge clk); t++; end
      check_val($sformatf("out_valid%0d", k), 64'(bus.out_valid), 64'd1);
      check_val($sformatf("out_data%0d", k), bus.out_data, exp_c(k, f));
      $display("OUT k=%0d addr_word=%0d data=%h", k, k, bus.out_data);
      if (k == stall_k) begin
        bus.out_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          check_val("stall_data", bus.out_data, exp_c(k, f));
          check_val("stall_noread", 64'(bus.tpu_addr), 64'd0);
        end
        bus.out_ready = 1'b1;
      end
      @(negedge clk);
      if (k < 2*DIM - 1)
        check_val($sformatf("next_rd%0d", k + 1), 64'(bus.tpu_addr), 64'(16'h300 + 8 * (k + 1)));
      else
        check_val("done_pulse", 64'(bus.done), 64'd1);
      check_val("out_valid_drop", 64'(bus.out_valid), 64'd0);
    end
    @(negedge clk);
    check_val("done_clear", 64'(bus.done), 64'd0);
    check_val("idle_ready", 64'(bus.job_ready), 64'd1);
    bus.out_ready = 1'b0;
  endtask

  task automatic check_bus();
    logic [15:0] ea [$];
    logic [63:0] ed [$];
    for (int r = 0; r < DIM; r++) begin ea.push_back(16'(16'h100 + 8 * r)); ed.push_back(a_row(r)); end
    for (int i = 0; i < DIM; i++) begin ea.push_back(16'h200); ed.push_back(b_row(i)); end
`ifdef TPU_DRV_CLEAR_C_EN
    for (int k = 0; k < 2*DIM; k++) begin ea.push_back(16'(16'h300 + 8 * k)); ed.push_back(64'd0); end
`endif
    ea.push_back(16'h400);
    ed.push_back(64'd0);
    check_val("n_writes", 64'(wr_addr_q.size()), 64'(ea.size()));
    for (int i = 0; i < ea.size() && i < wr_addr_q.size(); i++) begin
      check_val($sformatf("wr_addr%0d", i), 64'(wr_addr_q[i]), 64'(ea[i]));
      check_val($sformatf("wr_data%0d", i), wr_data_q[i], ed[i]);
    end
    check_val("n_reads", 64'(rd_addr_q.size()), 64'(2 * DIM));
    for (int i = 0; i < 2*DIM && i < rd_addr_q.size(); i++)
      check_val($sformatf("rd_addr%0d", i), 64'(rd_addr_q[i]), 64'(16'h300 + 8 * i));
    check_val("wait_gap", 64'(first_rd_cyc - start_cyc), 64'd33);
  endtask

  initial begin
    int t, base;
    bus.job_valid = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_rw", 64'(bus.tpu_r_w), 64'd0);
    check_val("rst_addr", 64'(bus.tpu_addr), 64'd0);
    check_val("rst_job_ready", 64'(bus.job_ready), 64'd1);
    check_val("rst_in_ready", 64'(bus.in_ready), 64'd0);
    check_val("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check_val("rst_out_data", bus.out_data, 64'd0);
    check_val("rst_done", 64'(bus.done), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Asynchronous reset while A rows are being written.
    request_job();
    for (int r = 0; r < 3; r++) send_word(a_row(r));
    bus.in_valid = 1'b0;
    check_val("pre_arst_rw", 64'(bus.tpu_r_w), 64'd1);
    check_val("pre_arst_addr", 64'(bus.tpu_addr), 64'h110);
    check_val("pre_arst_in_ready", 64'(bus.in_ready), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check_val("arst_rw", 64'(bus.tpu_r_w), 64'd0);
    check_val("arst_addr", 64'(bus.tpu_addr), 64'd0);
    check_val("arst_wdata", bus.tpu_wdata, 64'd0);
    check_val("arst_in_ready", 64'(bus.in_ready), 64'd0);
    check_val("arst_job_ready", 64'(bus.job_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("JOB 1 continuous");
    run_inputs(1'b0);
    collect(-1, 1);
    check_bus();

    $display("JOB 2 input bubbles, output stall at word 3");
    run_inputs(1'b1);
`ifdef TPU_DRV_CLEAR_C_EN
    collect(3, 1);
`else
    collect(3, 2);
`endif
    check_bus();

    $display("JOB 3 reset during WAIT");
    base = n_start;
    run_inputs(1'b0);
    t = 0;
    while (n_start == base && t < 100) begin @(negedge clk); t++; end
    check_val("start_seen", 64'(n_start - base), 64'd1);
    repeat (5) @(negedge clk);
    check_val("wait_busy", 64'(bus.job_ready), 64'd0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
`ifdef TPU_DRV_CLEAR_C_EN
    check_val("abort_writes", 64'(wr_addr_q.size()), 64'd33);
`else
    check_val("abort_writes", 64'(wr_addr_q.size()), 64'd17);
`endif
    check_val("abort_reads", 64'(rd_addr_q.size()), 64'd0);
    check_val("abort_job_ready", 64'(bus.job_ready), 64'd1);
    check_val("abort_out_valid", 64'(bus.out_valid), 64'd0);

    $display("JOB 4 after abort");
    run_inputs(1'b0);
`ifdef TPU_DRV_CLEAR_C_EN
    collect(-1, 1);
`else
    collect(-1, 4);
`endif
    check_bus();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
